// File: rtl/uart_cal_ctrl.sv
// UART calculator sequencer: gathers an A/op/B frame from the receiver, computes a
// 16-bit result and sends it to the transmitter as two bytes, MSB first.
module uart_cal_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 3000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       op_err,
    output logic       drop
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [7:0] OP_ADD = 8'h2B;
    localparam logic [7:0] OP_SUB = 8'h2D;
    localparam logic [7:0] OP_MUL = 8'h2A;
    localparam logic [7:0] OP_AND = 8'h26;

    typedef enum logic [3:0] {
        WAIT_A, WAIT_OP, WAIT_B, CALC,
        SEND_HI, GUARD_HI, WAIT_HI,
        SEND_LO, GUARD_LO, WAIT_LO
    } state_t;

    state_t           state, state_d;
    logic [7:0]       a, a_d, b, b_d, op, op_d;
    logic [15:0]      result, result_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             tx_start_d, busy_d, op_err_d, drop_d;
    logic [7:0]       tx_data_d;
    logic             timeout;

    function automatic logic op_valid(input logic [7:0] code);
        return (code == OP_ADD) || (code == OP_SUB) || (code == OP_MUL) || (code == OP_AND);
    endfunction

    function automatic logic [15:0] calc(input logic [7:0] x, input logic [7:0] code,
                                         input logic [7:0] y);
        logic [15:0] r;
        r = 16'h0000;
        case (code)
            OP_ADD:  r = 16'(x) + 16'(y);
            OP_SUB:  r = 16'(x) - 16'(y);
            OP_MUL:  r = 16'(x) * 16'(y);
            OP_AND:  r = {8'h00, x & y};
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    assign timeout = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= WAIT_A;
        else        state <= state_d;
    end

    // Next state; a byte arriving on the final timeout cycle takes priority.
    always_comb begin
        state_d = state;
        case (state)
            WAIT_A:   if (rx_valid) state_d = WAIT_OP;
            WAIT_OP: begin
                if (rx_valid)     state_d = op_valid(rx_data) ? WAIT_B : WAIT_A;
                else if (timeout) state_d = WAIT_A;
            end
            WAIT_B: begin
                if (rx_valid)     state_d = CALC;
                else if (timeout) state_d = WAIT_A;
            end
            CALC:     state_d = SEND_HI;
            SEND_HI:  state_d = GUARD_HI;
            GUARD_HI: state_d = WAIT_HI;
            WAIT_HI:  if (!tx_busy) state_d = SEND_LO;
            SEND_LO:  state_d = GUARD_LO;
            GUARD_LO: state_d = WAIT_LO;
            WAIT_LO:  if (!tx_busy) state_d = WAIT_A;
            default:  state_d = WAIT_A;
        endcase
    end

    // Next values of the datapath and of the registered outputs.
    always_comb begin
        a_d        = a;
        b_d        = b;
        op_d       = op;
        result_d   = result;
        cnt_d      = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data;
        op_err_d   = 1'b0;
        drop_d     = 1'b0;
        busy_d     = (state_d != WAIT_A);
        case (state)
            WAIT_A: if (rx_valid) a_d = rx_data;
            WAIT_OP: begin
                if (rx_valid) begin
                    if (op_valid(rx_data)) op_d     = rx_data;
                    else                   op_err_d = 1'b1;
                end else if (!timeout) begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            WAIT_B: begin
                if (rx_valid)      b_d   = rx_data;
                else if (!timeout) cnt_d = cnt + CNT_W'(1);
            end
            CALC: begin
                result_d = calc(a, op, b);
                drop_d   = rx_valid;
            end
            SEND_HI: begin
                tx_start_d = 1'b1;
                tx_data_d  = result[15:8];
                drop_d     = rx_valid;
            end
            SEND_LO: begin
                tx_start_d = 1'b1;
                tx_data_d  = result[7:0];
                drop_d     = rx_valid;
            end
            default: drop_d = rx_valid;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            a        <= 8'h00;
            b        <= 8'h00;
            op       <= 8'h00;
            result   <= 16'h0000;
            cnt      <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            op_err   <= 1'b0;
            drop     <= 1'b0;
        end else begin
            a        <= a_d;
            b        <= b_d;
            op       <= op_d;
            result   <= result_d;
            cnt      <= cnt_d;
            tx_start <= tx_start_d;
            tx_data  <= tx_data_d;
            busy     <= busy_d;
            op_err   <= op_err_d;
            drop     <= drop_d;
        end
    end

endmodule

// File: doc/uart_cal_ctrl.md
# uart_cal_ctrl

Sequencing controller for the UART calculator. It sits between the UART receiver (byte stream `rx_data`/`rx_valid`) and the UART transmitter (`tx_start`/`tx_data`/`tx_busy`). It assembles a three-byte command frame (operand A, operator, operand B) and computes a 16-bit result. It then schedules the result onto the transmitter as two bytes, MSB first, respecting the transmitter's busy handshake.

## Interface
- `TIMEOUT_CYC`, default 3000: inter-byte timeout in clocks for a partially received frame (fits 12-bit counter; 3000 = 20 byte-times at 15 clk/bit).
- `clk`  in  1  system clock, rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  received byte; valid only when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe from receiver.
- `tx_busy`  in  1  transmitter busy; goes high the cycle after `tx_start` and stays high until the stop bit ends.
- `tx_start`  out  1  one-cycle request to transmit `tx_data`.
- `tx_data`  out  8  byte to transmit; stable from the `tx_start` cycle until `tx_busy` falls.
- `busy`  out  1  high whenever state ≠ WAIT_A.
- `op_err`  out  1  one-cycle pulse when an invalid operator byte is received.
- `drop`  out  1  one-cycle pulse when `rx_valid` arrives in a non-receive state (byte discarded).

## Operation
- Clock and reset: one clock `clk`; reset `n_rst` asynchronous active-low.
- Reset values: state=WAIT_A; `tx_start`=0, `tx_data`=8'h00, `busy`=0, `op_err`=0, `drop`=0; A, B, op, result registers and timeout counter=0.
- States and transitions:
  - WAIT_A: on `rx_valid`, latch A, go to WAIT_OP.
  - WAIT_OP: on `rx_valid`, check the byte against the valid operator set.
    - Valid: latch op, go to WAIT_B.
    - Invalid: pulse `op_err`, go to WAIT_A.
  - WAIT_B: on `rx_valid`, latch B, go to CALC.
  - CALC: load `result`, go to SEND_HI.
  - SEND_HI: drive `tx_start`=1, `tx_data`=result[15:8], go to GUARD_HI.
  - GUARD_HI: one cycle, `tx_busy` ignored; go to WAIT_HI.
  - WAIT_HI: when `tx_busy`=0, go to SEND_LO.
  - SEND_LO, GUARD_LO, WAIT_LO: same as the HI states with result[7:0]; WAIT_LO returns to WAIT_A.
- Operators and arithmetic (all 16-bit):
  - 8'h2B '+': {8'h00,A}+{8'h00,B}, range 0..510.
  - 8'h2D '-': {8'h00,A}-{8'h00,B}, wraps mod 2^16 (two's complement).
  - 8'h2A '*': A*B unsigned, max 16'hFE01.
  - 8'h26 '&': {8'h00, A&B}.
  - Any other operator byte is invalid.
- Timeout:
  - The counter clears on every accepted byte and in WAIT_A.
  - It increments each cycle in WAIT_OP and WAIT_B.
  - When it reaches TIMEOUT_CYC-1 with no `rx_valid` that cycle, go to WAIT_A; partial frame discarded, no output.
  - If `rx_valid` arrives on that same cycle, the byte is accepted; the byte wins.
- Bytes received in CALC, SEND_*, GUARD_* or WAIT_HI/LO are discarded with a `drop` pulse; there is no buffering.
- Reset mid-operation aborts immediately, including during a transmit. `tx_start` never glitches high out of reset.

## Timing
- All outputs are registered.
- `rx_valid` for B sampled at edge n:
  - CALC during cycle n..n+1.
  - `tx_start` high for the single cycle following edge n+2, with `tx_data`=result[15:8].
- Second `tx_start` (low byte) is asserted 1 cycle after WAIT_HI samples `tx_busy`=0.
- Minimum gap between the two `tx_start` pulses is 3 cycles (SEND, GUARD, WAIT).
- `busy` falls the cycle after WAIT_LO sees `tx_busy`=0. A new A byte is accepted from that cycle on.
- `op_err` and `drop` are exactly one cycle wide, asserted the cycle after the offending `rx_valid`.
- `tx_busy` must be low in every WAIT_x cycle following GUARD before the controller advances. A `tx_busy` that never rises (ideal transmitter) is legal: the controller advances after GUARD.

## Test plan
- Reset mid-frame: bytes 8'h05 and 8'h2B, then pulse `n_rst` low → all outputs 0, state WAIT_A. A following frame 8'h01,8'h2B,8'h01 yields 8'h00,8'h02.
- Add: rx 8'h03, 8'h2B, 8'h04 → `tx_start` exactly 2 cycles after the last `rx_valid` edge with `tx_data`=8'h00. The second `tx_start` after `tx_busy` falls carries 8'h07.
- Multiply and subtract:
  - Frame FF,2A,FF → bytes 8'hFE then 8'h01.
  - Frame 02,2D,05 → bytes 8'hFF then 8'hFD.
- Invalid operator: rx 8'h10, 8'h41 → one-cycle `op_err`, no `tx_start`, `busy` low next cycle. Then 8'h10,8'h26,8'h0F → 8'h00,8'h00.
- Timeout: rx 8'h09 then silence for TIMEOUT_CYC cycles → return to WAIT_A, no transmit. Separately, a byte arriving on the exact final count cycle is accepted.
- Drop during transmit: inject `rx_valid` with 8'h55 while `tx_busy`=1 in WAIT_HI → `drop` pulse, transmitted bytes unchanged. The next frame is parsed normally.
